copro_ctrl: RTL and testbench
=============================

# copro_ctrl

Multicycle issue/stall controller for the custom-0 coprocessor instructions of the single-cycle RISC-V core. Decodes custom-0 instructions, stalls the core, starts one of `NUNITS` coprocessor units (GCD, LCM, …) with a start/done handshake, enforces a timeout, and produces a register-file write-back. Sits beside the main controller; its `stall` gates the PC and register-file enables.

## Interface
Parameters:
- `XLEN`, 32: operand/result width.
- `NUNITS`, 2: number of attached units, 1..8; unit index = `funct3`.
- `TIMEOUT`, 255: maximum WAIT cycles; 0 disables the timeout. Counter width is `$clog2(TIMEOUT+1)`, minimum 1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_valid` in 1: the current instruction is valid.
- `op` in 7, `funct3` in 3, `funct7` in 7, `rd` in 5: instruction fields.
- `rs1val`, `rs2val` in XLEN: register operands.
- `stall` out 1: hold PC and block retirement.
- `cp_start` out NUNITS: one-hot start pulse.
- `cp_a`, `cp_b` out XLEN: operands to the units.
- `cp_done` in NUNITS: per-unit done pulse.
- `cp_result` in NUNITS*XLEN: unit *i* result in bits `[i*XLEN +: XLEN]`.
- `wb_we` out 1, `wb_rd` out 5, `wb_data` out XLEN: write-back.
- `illegal` out 1: illegal custom-0 encoding, single-cycle pulse.
- `timeout_err` out 1: unit did not respond, single-cycle pulse.

## Operation
- FSM states: IDLE, ISSUE, WAIT, WB.
- **Hit:** `instr_valid && op == CUSTOM0` (7'b0001011).
- **Legal hit:** `funct7 == 0 && funct3 < NUNITS`.
- **IDLE:**
  - Legal hit: latch `rd`, unit = `funct3`, `rs1val`, `rs2val`; go to ISSUE.
  - Illegal hit: pulse `illegal` combinationally this cycle, no stall, stay in IDLE. The core retires it as a NOP.
- **ISSUE:** `cp_start[unit]` = 1 for exactly this cycle. `cp_done` is ignored. Go to WAIT; clear the wait counter.
- **WAIT:**
  - Counter increments each cycle.
  - `cp_done[unit]`: capture `cp_result` slice, go to WB.
  - Else if `TIMEOUT != 0` and counter == TIMEOUT: pulse `timeout_err`, capture 0, go to WB.
  - If done and timeout occur in the same cycle, done wins and no error is raised.
- **WB:**
  - `wb_we = (rd_q != 0)`, `wb_rd = rd_q`, `wb_data` = captured value.
  - `stall` = 0, so the core retires the instruction at this edge. Always return to IDLE.
  - No new instruction is accepted in WB.
- `stall = (IDLE && legal hit) || ISSUE || WAIT`. It is combinational in IDLE so the PC does not advance on the decode cycle.
- `cp_a`/`cp_b` carry the latched operands, stable from ISSUE through WB. In IDLE they are 0.
- `cp_done` from non-selected units is ignored in all states. `cp_done` in IDLE, ISSUE or WB is ignored.
- `rd == 0`: full handshake and stall, `wb_we` = 0.

## Timing
- **Reset values:** state IDLE; all registered outputs and latches 0. `stall`, `cp_start`, `wb_we`, `illegal`, `timeout_err` are 0 unless driven by the IDLE decode.
- **Latency**, legal instruction decoded in cycle T:
  - ISSUE at T+1 (`cp_start`).
  - Earliest done at T+2.
  - WB at T+3.
  - Minimum 3 stalled cycles, retire at the end of T+3.
- Done at WAIT cycle *k* (k ≥ 1): WB at T+2+k.
- **Timeout:** with no done, WB occurs at T+2+TIMEOUT+1. `timeout_err` is asserted in the last WAIT cycle.
- **Reset mid-operation:** FSM returns to IDLE next edge, `cp_start`/`stall` drop, no write-back. The units share `reset`.
- Back-to-back custom-0 instructions: the second is decoded in the cycle after WB. No overlap.

## Structure
- Package `copro_pkg`:
  - `CUSTOM0` opcode constant.
  - `copro_state_t` enum (IDLE, ISSUE, WAIT, WB).
  - Unit index constants `CP_GCD = 0`, `CP_LCM = 1`.
- Sub-module `copro_timer`: parametrised wait counter with `clr`, `en`, `expired`; `expired` is held at 0 when TIMEOUT = 0.
- Result mux and one-hot start decode stay inline.

## Test plan
- **GCD path:** rs1 = 48, rs2 = 18, funct3 = 0, rd = 5; unit 0 done 4 cycles after start with 6 → stall for T..T+5, `wb_we` = 1, `wb_rd` = 5, `wb_data` = 6 at T+6.
- **LCM path:** funct3 = 1, rs1 = 4, rs2 = 6, done with 12 at earliest cycle (T+2) → WB at T+3, `wb_data` = 12; `cp_start` = 2'b10 only at T+1.
- **Illegal encodings:** funct3 = 3 with NUNITS = 2, or funct7 = 1 → `illegal` = 1 for one cycle, `stall` = 0, no `cp_start`, no write.
- **Timeout:** TIMEOUT = 4, done never asserted → `timeout_err` at T+6, WB at T+7 with `wb_data` = 0. Repeat with done exactly at the 4th WAIT cycle → no error, result written.
- **rd = 0 and spurious done:** rd = 0 → `wb_we` stays 0. `cp_done[1]` pulsed while waiting on unit 0 → ignored, still waits.
- **Reset in WAIT:** reset pulsed → next cycle IDLE, `stall` = 0, `cp_start` = 0, no write. A following legal instruction completes normally.

Source files
------------

// File: rtl/copro_pkg.sv
// Shared constants and FSM state type for the custom-0 coprocessor controller.
// Unit indices match the funct3 field of the instruction.
package copro_pkg;

    localparam logic [6:0] CUSTOM0 = 7'b0001011;

    localparam int CP_GCD = 0;
    localparam int CP_LCM = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        WB    = 2'd3
    } copro_state_t;

endpackage

// File: rtl/copro_timer.sv
// Wait-cycle counter: cleared on issue, counts while waiting, flags TIMEOUT reached.
// expired is tied low when TIMEOUT = 0 so the controller waits indefinitely.
module copro_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = ($clog2(TIMEOUT + 1) < 1) ? 1 : $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    generate
        if (TIMEOUT == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            assign expired = (r_cnt == CW'(TIMEOUT));
        end
    endgenerate

endmodule

// File: rtl/copro_ctrl.sv
// Issue/stall controller for custom-0 coprocessor instructions: decode, start, wait, write back.
// Stalls the core from decode until the write-back cycle; one instruction in flight at a time.
module copro_ctrl
    import copro_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int NUNITS  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid,
    input  logic [6:0]             op,
    input  logic [2:0]             funct3,
    input  logic [6:0]             funct7,
    input  logic [4:0]             rd,
    input  logic [XLEN-1:0]        rs1val,
    input  logic [XLEN-1:0]        rs2val,
    output logic                   stall,
    output logic [NUNITS-1:0]      cp_start,
    output logic [XLEN-1:0]        cp_a,
    output logic [XLEN-1:0]        cp_b,
    input  logic [NUNITS-1:0]      cp_done,
    input  logic [NUNITS*XLEN-1:0] cp_result,
    output logic                   wb_we,
    output logic [4:0]             wb_rd,
    output logic [XLEN-1:0]        wb_data,
    output logic                   illegal,
    output logic                   timeout_err
);

    copro_state_t r_state;
    copro_state_t w_state_nxt;

    logic [4:0]        r_rd;
    logic [2:0]        r_unit;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic [XLEN-1:0]   r_res;

    logic              w_hit;
    logic              w_legal;
    logic [NUNITS-1:0] w_onehot;
    logic              w_done;
    logic              w_expired;
    logic [XLEN-1:0]   w_sel_res;

    assign w_hit    = instr_valid && (op == CUSTOM0);
    assign w_legal  = w_hit && (funct7 == 7'd0) && (32'(funct3) < NUNITS);
    assign w_onehot = NUNITS'(1) << r_unit;
    assign w_done   = |(cp_done & w_onehot);

    always_comb begin
        w_sel_res = '0;
        for (int i = 0; i < NUNITS; i++) begin
            if (r_unit == 3'(i)) begin
                w_sel_res = cp_result[i*XLEN +: XLEN];
            end
        end
    end

    copro_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clr     (r_state == ISSUE),
        .en      (r_state == WAIT),
        .expired (w_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        cp_start    = '0;
        illegal     = 1'b0;
        timeout_err = 1'b0;
        wb_we       = 1'b0;
        case (r_state)
            IDLE: begin
                // Decode-cycle stall is combinational so the PC never moves past the instruction.
                stall   = w_legal;
                illegal = w_hit && !w_legal;
                if (w_legal) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                stall       = 1'b1;
                cp_start    = w_onehot;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                stall       = 1'b1;
                timeout_err = w_expired && !w_done;
                if (w_done || w_expired) begin
                    w_state_nxt = WB;
                end
            end
            WB: begin
                wb_we       = (r_rd != 5'd0);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd   <= '0;
            r_unit <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_res  <= '0;
        end else begin
            if (r_state == IDLE && w_legal) begin
                r_rd   <= rd;
                r_unit <= funct3;
                r_a    <= rs1val;
                r_b    <= rs2val;
            end
            if (r_state == WAIT) begin
                if (w_done) begin
                    r_res <= w_sel_res;
                end else if (w_expired) begin
                    r_res <= '0;
                end
            end
        end
    end

    assign cp_a    = (r_state == IDLE) ? '0 : r_a;
    assign cp_b    = (r_state == IDLE) ? '0 : r_b;
    assign wb_rd   = r_rd;
    assign wb_data = (r_state == WB) ? r_res : '0;

endmodule

// File: tb/tb_copro_ctrl.sv
// Scoreboard bench for copro_ctrl with two units and a short timeout.
module tb_copro_ctrl;
    import copro_pkg::*;

    localparam int XLEN    = 32;
    localparam int NUNITS  = 2;
    localparam int TIMEOUT = 4;

    typedef struct {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } wb_exp_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   instr_valid;
    logic [6:0]             op;
    logic [2:0]             funct3;
    logic [6:0]             funct7;
    logic [4:0]             rd;
    logic [XLEN-1:0]        rs1val;
    logic [XLEN-1:0]        rs2val;
    logic                   stall;
    logic [NUNITS-1:0]      cp_start;
    logic [XLEN-1:0]        cp_a;
    logic [XLEN-1:0]        cp_b;
    logic [NUNITS-1:0]      cp_done;
    logic [NUNITS*XLEN-1:0] cp_result;
    logic                   wb_we;
    logic [4:0]             wb_rd;
    logic [XLEN-1:0]        wb_data;
    logic                   illegal;
    logic                   timeout_err;

    int n_checks = 0;
    int n_errors = 0;
    wb_exp_t exp_q[$];

    copro_ctrl #(.XLEN(XLEN), .NUNITS(NUNITS), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .op(op),
        .funct3(funct3), .funct7(funct7), .rd(rd), .rs1val(rs1val), .rs2val(rs2val),
        .stall(stall), .cp_start(cp_start), .cp_a(cp_a), .cp_b(cp_b),
        .cp_done(cp_done), .cp_result(cp_result), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .illegal(illegal), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write-back monitor: every observed write must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && wb_we) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", 1, 0);
            end else begin
                wb_exp_t e;
                e = exp_q.pop_front();
                chk("wb_rd", wb_rd, e.rd);
                chk("wb_data", wb_data, e.data);
            end
        end
    end

    // Legal op; done_k = WAIT cycle of the done pulse (0 = never), spur = noise on other unit.
    task automatic legal_op(input logic [2:0] f3, input logic [4:0] d, input logic [XLEN-1:0] a,
                            input logic [XLEN-1:0] b, input int done_k, input logic [XLEN-1:0] res,
                            input logic spur);
        logic [NUNITS-1:0] oh;
        logic [NUNITS-1:0] other;
        int n_wait;
        logic got_done;
        wb_exp_t e;
        oh       = NUNITS'(1) << f3;
        other    = ~oh;
        got_done = (done_k != 0) && (done_k <= TIMEOUT + 1);
        n_wait   = got_done ? done_k : TIMEOUT + 1;

        instr_valid = 1'b1; op = CUSTOM0; funct3 = f3; funct7 = 7'd0; rd = d;
        rs1val = a; rs2val = b; cp_done = '0;
        #1;
        chk("dec_stall", stall, 1);
        chk("dec_illegal", illegal, 0);
        chk("dec_cp_a_idle", cp_a, 0);
        chk("dec_start", cp_start, 0);
        if (d != 5'd0) begin
            e.rd   = d;
            e.data = got_done ? res : '0;
            exp_q.push_back(e);
        end
        tick();
        cp_done   = spur ? oh : '0;
        cp_result = {$urandom, $urandom};
        #1;
        chk("issue_start", cp_start, oh);
        chk("issue_stall", stall, 1);
        chk("issue_cp_a", cp_a, a);
        chk("issue_cp_b", cp_b, b);
        tick();
        for (int c = 1; c <= n_wait; c++) begin
            cp_result = {$urandom, $urandom};
            cp_done   = '0;
            if (c == done_k) begin
                cp_done = oh;
                cp_result[f3*XLEN +: XLEN] = res;
            end else if (spur && c == 1) begin
                cp_done = other;
            end
            #1;
            chk("wait_stall", stall, 1);
            chk("wait_start", cp_start, 0);
            chk("wait_we", wb_we, 0);
            chk("wait_timeout", timeout_err, (c == n_wait) && !got_done);
            tick();
        end
        cp_done = '0;
        #1;
        chk("wb_stall", stall, 0);
        chk("wb_we_flag", wb_we, d != 5'd0);
        chk("wb_timeout", timeout_err, 0);
        chk("wb_illegal", illegal, 0);
        chk("wb_cp_a", cp_a, a);
        tick();
    endtask

    task automatic illegal_op(input logic [2:0] f3, input logic [6:0] f7);
        instr_valid = 1'b1; op = CUSTOM0; funct3 = f3; funct7 = f7; rd = 5'd3;
        rs1val = 32'h11; rs2val = 32'h22;
        #1;
        chk("ill_pulse", illegal, 1);
        chk("ill_stall", stall, 0);
        tick();
        instr_valid = 1'b0;
        #1;
        chk("ill_after", illegal, 0);
        chk("ill_start", cp_start, 0);
        chk("ill_stall_after", stall, 0);
        tick();
        chk("ill_nostart", cp_start, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; instr_valid = 1'b0; op = '0; funct3 = '0; funct7 = '0; rd = '0;
        rs1val = '0; rs2val = '0; cp_done = '0; cp_result = '0;
        repeat (3) tick();
        chk("rst_stall", stall, 0);
        chk("rst_start", cp_start, 0);
        chk("rst_we", wb_we, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_timeout", timeout_err, 0);
        chk("rst_cp_a", cp_a, 0);
        reset = 1'b0;
        tick();

        // Non-custom opcode must be invisible.
        instr_valid = 1'b1; op = 7'b0110011; funct3 = 3'd0; funct7 = 7'd0;
        #1;
        chk("other_op_stall", stall, 0);
        chk("other_op_illegal", illegal, 0);
        tick();

        legal_op(3'(CP_GCD), 5'd5, 32'd48, 32'd18, 4, 32'd6, 1'b0);
        legal_op(3'(CP_LCM), 5'd7, 32'd4, 32'd6, 1, 32'd12, 1'b0);
        illegal_op(3'd3, 7'd0);
        illegal_op(3'd0, 7'd1);
        illegal_op(3'd2, 7'd0);
        legal_op(3'd0, 5'd9, 32'd10, 32'd20, 0, 32'hdead, 1'b0);
        legal_op(3'd1, 5'd10, 32'd1, 32'd2, 4, 32'h1234, 1'b0);
        legal_op(3'd0, 5'd11, 32'd3, 32'd4, TIMEOUT + 1, 32'h5678, 1'b0);
        legal_op(3'd0, 5'd0, 32'd7, 32'd8, 2, 32'h99, 1'b1);
        legal_op(3'd0, 5'd12, 32'd7, 32'd8, 3, 32'h77, 1'b1);

        // Reset while waiting: no write-back may follow.
        instr_valid = 1'b1; op = CUSTOM0; funct3 = 3'd1; funct7 = 7'd0; rd = 5'd13;
        rs1val = 32'd5; rs2val = 32'd6;
        tick();
        tick();
        tick();
        chk("rst_mid_in_wait", stall, 1);
        reset = 1'b1; instr_valid = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        chk("rst_mid_stall", stall, 0);
        chk("rst_mid_start", cp_start, 0);
        chk("rst_mid_we", wb_we, 0);
        repeat (6) begin
            tick();
            chk("rst_mid_idle", stall, 0);
        end
        legal_op(3'd1, 5'd14, 32'd9, 32'd6, 2, 32'd18, 1'b0);

        for (int i = 0; i < 8; i++) begin
            legal_op(3'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, $urandom,
                     int'($urandom_range(0, 6)), $urandom, 1'($urandom_range(0, 1)));
        end

        instr_valid = 1'b0;
        repeat (3) tick();
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
